// File: rtl/compare_seq_ctrl.sv
// compare_seq_ctrl: sequential magnitude comparator stepping one 2-bit digit
// pair per cycle, MSB first, under a start/done handshake.
// Ports: clk, rst (sync, active-high), start, A, B -> busy, done,
//        A_lt_B, A_gt_B, A_eq_B.
// Optional: define COMPARE_EARLY_EXIT_EN to finish on the first mismatch.
module compare_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_lt_B,
    output logic             A_gt_B,
    output logic             A_eq_B
);

    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             lt_r;
    logic             gt_r;

    logic [1:0] a_dig;
    logic [1:0] b_dig;
    logic       dec_lt;
    logic       dec_gt;
    logic       last;

    assign a_dig = a_sh[WIDTH-1 -: 2];
    assign b_dig = b_sh[WIDTH-1 -: 2];

    // A recorded decision blocks any later digit from claiming the other side.
    assign dec_lt = lt_r | (!gt_r && (a_dig < b_dig));
    assign dec_gt = gt_r | (!lt_r && (a_dig > b_dig));

`ifdef COMPARE_EARLY_EXIT_EN
    assign last = (cnt == '0) || dec_lt || dec_gt;
`else
    assign last = (cnt == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            lt_r   <= 1'b0;
            gt_r   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            A_lt_B <= 1'b0;
            A_gt_B <= 1'b0;
            A_eq_B <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        cnt    <= CW'(N - 1);
                        lt_r   <= 1'b0;
                        gt_r   <= 1'b0;
                        A_lt_B <= 1'b0;
                        A_gt_B <= 1'b0;
                        A_eq_B <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    lt_r <= dec_lt;
                    gt_r <= dec_gt;
                    a_sh <= a_sh << 2;
                    b_sh <= b_sh << 2;
                    cnt  <= cnt - CW'(1);
                    // Flags stay clear during the scan and appear with done.
                    if (last) begin
                        A_lt_B <= dec_lt;
                        A_gt_B <= dec_gt;
                        A_eq_B <= !(dec_lt || dec_gt);
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// tb_compare_seq_ctrl: table-driven and hand-sequenced checks of
// compare_seq_ctrl with a queue of expected results per accepted start.
module tb_compare_seq_ctrl;

    localparam int W = 8;
    localparam int N = W / 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         A_lt_B;
    logic         A_gt_B;
    logic         A_eq_B;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         lt;
        logic         gt;
        logic         eq;
    } vec_t;

    typedef struct {
        logic  lt;
        logic  gt;
        logic  eq;
        int    lat;
        string name;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[10];

    compare_seq_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .A_lt_B (A_lt_B),
        .A_gt_B (A_gt_B),
        .A_eq_B (A_eq_B)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycles from start sampling to done, from the digit sequence.
    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef COMPARE_EARLY_EXIT_EN
        for (int j = 1; j <= N; j++) begin
            if (a[W-2*j +: 2] != b[W-2*j +: 2]) return j + 1;
        end
`endif
        return N + 1;
    endfunction

    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic lt, input logic gt, input logic eq,
                           input string nm, input bit hammer);
        exp_t e;
        int   cyc;
        int   busy_cyc;
        int   late_done;
        bit   seen;
        bit   flag_bad;
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        e.lt   = lt;
        e.gt   = gt;
        e.eq   = eq;
        e.lat  = exp_lat(a, b);
        e.name = nm;
        sbq.push_back(e);
        @(posedge clk);
        cyc      = 0;
        busy_cyc = 0;
        seen     = 1'b0;
        flag_bad = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (hammer) begin
                A = W'($urandom);
                B = W'($urandom);
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1'b1;
                e = sbq.pop_front();
                chk({e.name, "_flags"}, {A_lt_B, A_gt_B, A_eq_B},
                    {e.lt, e.gt, e.eq});
                chk({e.name, "_latency"}, cyc, e.lat);
            end else if (A_lt_B || A_gt_B || A_eq_B) begin
                flag_bad = 1'b1;
            end
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
        chk({nm, "_scan_flags_zero"}, int'(flag_bad), 0);
        chk({nm, "_busy_cycles"}, busy_cyc, cyc);
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_after_done"}, {busy, done, A_lt_B, A_gt_B, A_eq_B},
            {2'b00, lt, gt, eq});
        if (hammer) begin
            late_done = 0;
            for (int i = 0; i < 2 * N + 4; i++) begin
                @(negedge clk);
                if (done || busy) late_done++;
            end
            chk({nm, "_no_second_op"}, late_done, 0);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           dcnt;

        vecs[0] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h35, 8'hC0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hA7, 8'hA4, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h40, 8'h3F, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h12, 8'h13, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'hC8, 8'hC4, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, done, A_lt_B, A_gt_B, A_eq_B}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {busy, done}, 0);

        for (int i = 0; i < 10; i++) begin
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].lt, vecs[i].gt,
                    vecs[i].eq, $sformatf("vec%0d", i), 1'b0);
        end

        // Flags hold in IDLE until the next start.
        repeat (3) @(negedge clk);
        chk("idle_hold", {A_lt_B, A_gt_B, A_eq_B}, 3'b100);

        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom);
            rb = (i == 0) ? ra : W'($urandom);
            run_cmp(ra, rb, ra < rb, ra > rb, ra == rb,
                    $sformatf("rnd%0d", i), 1'b0);
        end

        // start held with changing operands across the whole operation.
        run_cmp(8'h35, 8'hC0, 1'b1, 1'b0, 1'b0, "hammer", 1'b1);

        // Reset on the third SCAN cycle aborts without a done pulse.
        @(negedge clk);
        A     = 8'h00;
        B     = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_reset_state", {busy, done, A_lt_B, A_gt_B, A_eq_B}, 0);
        rst  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        run_cmp(8'h00, 8'h01, 1'b1, 1'b0, 1'b0, "post_abort", 1'b0);

        chk("scoreboard_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/compare_seq_ctrl.md
# compare_seq_ctrl

Sequential magnitude-compare controller. It compares two WIDTH-bit unsigned words by stepping a 2-bit digit comparator from the most significant digit pair down to the least significant one, under a start/done handshake. It reports less-than, greater-than and equal flags. It sits above the 2-bit comparator slice and lets one slice serve arbitrary even word widths, trading latency for area.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 2; N = WIDTH/2 digit pairs
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  reset, synchronous and active-high
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high in SCAN and DONE states
- done  output  1  one-cycle pulse; flags valid from this cycle on
- A_lt_B  output  1  result A < B
- A_gt_B  output  1  result A > B
- A_eq_B  output  1  result A == B

## Operation
- States are IDLE, SCAN and DONE. Reset enters IDLE.
- Reset values: busy=0, done=0, A_lt_B=0, A_gt_B=0, A_eq_B=0; internal registers are cleared.
- IDLE with start=1:
  - latch A and B into shift registers
  - load the digit counter with N-1
  - clear all three flags
  - go to SCAN
- IDLE with start=0 holds state and flags.
- SCAN, each cycle:
  - compare the top 2 bits of each shift register as unsigned 2-bit values
  - a digit mismatch with no decision yet records the decision: A_lt_B or A_gt_B is set and latched
  - later digits never overwrite a recorded decision
  - shift both registers left by 2 and decrement the counter
  - when the counter is 0 at evaluation, go to DONE
- DONE:
  - done=1 for exactly one cycle, then go to IDLE
  - if no mismatch was recorded, A_eq_B=1
  - the flag register holds the result through DONE and IDLE until the next accepted start clears it
- Exactly one flag is high after done, and all flags are 0 while SCAN is in progress.
- start is ignored in SCAN and DONE: no re-capture and no queueing. start in the DONE cycle is also ignored.
- A and B may change freely after capture without affecting the result.
- rst=1 in any state, including mid-SCAN, forces IDLE and the reset values next edge. No done pulse is issued for the aborted operation.

## Timing
- The start edge is at edge k, which moves the state to SCAN.
- Full scan: done is high in the cycle after edge k+N, i.e. N+1 cycles after start is sampled. For WIDTH=8 that is 5 cycles.
- Early exit (see Configuration): first mismatch at digit j (1 = MSB pair) gives done in the cycle after edge k+j, i.e. j+1 cycles after start.
- Equal operands always take N+1 cycles.
- Flags are registered. They change only on the start-accept edge (cleared) and on the edge entering DONE (result).
- The earliest next accepted start is the cycle after done, so back-to-back throughput is one compare per N+2 cycles.

## Configuration
- Macro: COMPARE_EARLY_EXIT_EN.
- Defined: a mismatch in SCAN moves directly to DONE on the same edge, and latency depends on data.
- Undefined: all N digits are always scanned and latency is fixed at N+1. This gives constant-time behaviour, and the flags are identical either way.

## Test plan
- WIDTH=8, A=0xA5, B=0xA5, start pulse → done 5 cycles after start; A_eq_B=1, A_lt_B=A_gt_B=0; busy high for 5 cycles.
- A=0x35, B=0xC0 (MSB digits 0 vs 3) → A_lt_B=1; done after 2 cycles with COMPARE_EARLY_EXIT_EN, after 5 without.
- A=0xA7, B=0xA4 (only the LSB digit differs, 3 vs 0) → A_gt_B=1, done after 5 cycles in both builds.
- A=0x40, B=0x3F (MSB digit decides gt, lower digits favour B) → A_gt_B=1; no later digit overwrites it.
- start, then start re-asserted with new operands every cycle while busy → a single done with the result of the first operands; the second request is ignored.
- rst=1 on the 3rd SCAN cycle of A=0x00, B=0x01 → next cycle busy=0, done=0, all flags 0; no done pulse ever issued; a following start compares normally.
